// File: rtl/clk_div_pkg.sv
// Shared types and reset settings for the clock divider bank.
package clk_div_pkg;

   typedef enum logic [1:0] {
      ALIGN  = 2'd0,
      SETTLE = 2'd1,
      LOCKED = 2'd2
   } clk_div_state_e;

   localparam int unsigned DIV_MIN   = 2;
   localparam int unsigned DEF_DIV   = 2;
   localparam int unsigned DEF_PHASE = 0;
   localparam int unsigned DEF_DUTY  = 1;

   // Channel-select width; a single-channel bank still gets one select bit.
   function automatic int unsigned chan_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration write port of the clock divider bank.
interface clk_div_bank_if
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CLOCKS = 3,
   parameter int unsigned DIV_W      = 16
);
   localparam int unsigned CHAN_W = chan_width(NUM_CLOCKS);

   logic              cfg_valid;
   logic              cfg_ready;
   logic [CHAN_W-1:0] cfg_chan;
   logic [DIV_W-1:0]  cfg_div;
   logic [DIV_W-1:0]  cfg_phase;
   logic [DIV_W-1:0]  cfg_duty;

   modport master (
      output cfg_valid, cfg_chan, cfg_div, cfg_phase, cfg_duty,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_chan, cfg_div, cfg_phase, cfg_duty,
      output cfg_ready
   );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: clamped settings, free-running counter, registered output and rise strobe.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic             align,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [DIV_W-1:0] cfg_phase,
   input  logic [DIV_W-1:0] cfg_duty,
   output logic             outclk,
   output logic             outclk_en
);

   logic [DIV_W-1:0] div_q, phase_q, duty_q, cnt_q;
   logic [DIV_W-1:0] div_c, phase_c;
   logic             hi;

   always_comb begin
      div_c   = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;
      phase_c = (cfg_phase >= div_c) ? div_c - 1'b1 : cfg_phase;
      hi      = cnt_q < duty_q;
   end

   // The >= wrap keeps the counter bounded if div shrinks before the realign lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q     <= DIV_W'(DEF_DIV);
         phase_q   <= DIV_W'(DEF_PHASE);
         duty_q    <= DIV_W'(DEF_DUTY);
         cnt_q     <= '0;
         outclk    <= 1'b0;
         outclk_en <= 1'b0;
      end else begin
         if (wr) begin
            div_q   <= div_c;
            phase_q <= phase_c;
            duty_q  <= cfg_duty;
         end
         if (align) begin
            cnt_q <= (phase_q != '0) ? div_q - phase_q : '0;
         end else begin
            cnt_q     <= (cnt_q >= div_q - 1'b1) ? '0 : cnt_q + 1'b1;
            outclk    <= hi;
            outclk_en <= hi && !outclk;
         end
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of phase-aligned clock dividers sharing one refclk, with realign/settle/lock sequencing.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CLOCKS  = 3,
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic                  refclk,
   input  logic                  rst,
   clk_div_bank_if.slave         cfg,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] outclk_en,
   output logic                  locked
);

   localparam int unsigned      CHAN_W      = chan_width(NUM_CLOCKS);
   localparam int unsigned      SET_W       = $clog2(LOCK_CYCLES + 1);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);

   clk_div_state_e   state_q, state_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic             ready, chan_ok, cfg_wr, align;

   assign ready         = !rst && (state_q != ALIGN);
   assign cfg.cfg_ready = ready;
   assign chan_ok       = 32'(cfg.cfg_chan) < NUM_CLOCKS;
   assign cfg_wr        = ready && cfg.cfg_valid && chan_ok;
   assign align         = (state_q == ALIGN);
   assign locked        = !rst && (state_q == LOCKED);

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q  <= ALIGN;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      unique case (state_q)
         ALIGN: begin
            state_d  = SETTLE;
            settle_d = '0;
         end
         SETTLE: begin
            if (cfg_wr)                       state_d = ALIGN;
            else if (settle_q == SETTLE_LAST) state_d = LOCKED;
            else                              settle_d = settle_q + 1'b1;
         end
         LOCKED: begin
            if (cfg_wr) state_d = ALIGN;
         end
         default: state_d = ALIGN;
      endcase
   end

   for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
      clk_div_chan #(
         .DIV_W (DIV_W)
      ) u_chan (
         .clk       (refclk),
         .rst       (rst),
         .wr        (cfg_wr && (cfg.cfg_chan == CHAN_W'(i))),
         .align     (align),
         .cfg_div   (cfg.cfg_div),
         .cfg_phase (cfg.cfg_phase),
         .cfg_duty  (cfg.cfg_duty),
         .outclk    (outclk[i]),
         .outclk_en (outclk_en[i])
      );
   end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CLOCKS SHALL exist: default 3, number of output channels, range 1-18.
REQ-002 Parameter DIV_W SHALL exist: default 16, width of the divide, phase and duty fields.
REQ-003 Parameter LOCK_CYCLES SHALL exist: default 16, refclk cycles that locked stays low after a realign; minimum 1.
REQ-004 Port refclk SHALL be input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 Port rst SHALL be input, 1 bit: reset, synchronous, active-high.
REQ-006 Port cfg_valid SHALL be input, 1 bit: a configuration write is offered.
REQ-007 Port cfg_ready SHALL be output, 1 bit: the block accepts a write.
REQ-008 Port cfg_chan SHALL be input, $clog2(NUM_CLOCKS) bits (minimum 1): target channel.
REQ-009 Port cfg_div SHALL be input, DIV_W bits: output period in refclk cycles.
REQ-010 Port cfg_phase SHALL be input, DIV_W bits: phase delay in refclk cycles.
REQ-011 Port cfg_duty SHALL be input, DIV_W bits: high time in refclk cycles.
REQ-012 Port outclk SHALL be output, NUM_CLOCKS bits: registered, divided square waves.
REQ-013 Port outclk_en SHALL be output, NUM_CLOCKS bits: one-cycle strobe per channel, coincident with the 0->1 transition of outclk[i].
REQ-014 Port locked SHALL be output, 1 bit: all channels are aligned and running with current settings.

Function
REQ-015 A write SHALL be accepted on a refclk edge where cfg_valid and cfg_ready are both high.
REQ-016 The FSM SHALL have states ALIGN, SETTLE and LOCKED.
REQ-017 ALIGN SHALL last one cycle: every channel counter loads its start value simultaneously, then the FSM enters SETTLE.
REQ-018 SETTLE SHALL count LOCK_CYCLES cycles, then enter LOCKED; locked is high only in LOCKED.
REQ-019 cfg_ready SHALL be low in ALIGN and high in SETTLE and LOCKED.
REQ-020 A write accepted in SETTLE or LOCKED with cfg_chan < NUM_CLOCKS SHALL update that channel's settings and move the FSM to ALIGN next cycle, so locked is low from the following cycle.
REQ-021 A write with cfg_chan >= NUM_CLOCKS SHALL be accepted and discarded: no settings change, no realign, locked unchanged.
REQ-022 Clamp rules SHALL apply: cfg_div < 2 stores 2; cfg_phase >= stored div stores div-1.
REQ-023 Each channel counter SHALL run 0..div-1 and wrap to 0.
REQ-024 At ALIGN the counter SHALL load (div-phase) when phase != 0, and 0 otherwise.
REQ-025 The next-state outclk[i] SHALL be (cnt < duty), registered, giving 1-cycle latency from the counter.
REQ-026 duty = 0 SHALL hold outclk[i] low with no strobes; duty >= div SHALL hold outclk[i] high with one strobe after ALIGN only.
REQ-027 During ALIGN, outclk and outclk_en SHALL hold their previous values.
REQ-028 All arithmetic SHALL be unsigned DIV_W-bit with no overflow: the maximum div is 2^DIV_W-1.

Reset
REQ-029 On rst, every channel SHALL be set to div=2, phase=0, duty=1, and all channels forced into ALIGN.
REQ-030 During rst, outclk and outclk_en SHALL be 0, locked 0 and cfg_ready 0; rst mid-SETTLE or mid-write SHALL discard the pending write.
REQ-031 After rst deasserts, locked SHALL rise exactly LOCK_CYCLES+1 cycles later if no writes occur.

Structure
REQ-032 Package clk_div_pkg SHALL hold the FSM state enum, DIV_MIN=2 and the default div/phase/duty constants.
REQ-033 Sub-module clk_div_chan SHALL hold one channel's settings, counter and output registers, generated NUM_CLOCKS times; the top holds the FSM and the write decode.

Verification
REQ-034 Defaults: release rst with LOCK_CYCLES=16 -> all outclk toggle at refclk/2, channels in phase, locked rises on cycle 17.
REQ-035 Write chan1 with div=20, phase=5, duty=10 -> locked low for 17 cycles; outclk[1] has a period of 20 and its rising edge lags outclk[0] by 5 cycles; outclk_en[1] fires once per 20 cycles.
REQ-036 Write div=0, phase=9, duty=0 -> stored div=2 and phase=1; outclk constant low with no strobes.
REQ-037 Write with cfg_chan=3 (NUM_CLOCKS=3) -> write accepted, locked stays high, outputs unchanged.
REQ-038 Hold cfg_valid high over two back-to-back writes -> second write stalls during ALIGN (cfg_ready=0), is accepted in SETTLE, and locked is reached only after the second write's SETTLE.
REQ-039 Assert rst mid-SETTLE after a write -> all channels return to defaults and the pending write is lost.
